// File: rtl/sw_debouncer_pkg.sv
// Shared defaults and sizing helper for the switch debouncer.
package sw_debouncer_pkg;

  localparam int unsigned DEF_NBITS           = 32'd8;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 32'd500000;

  // Counter width able to hold 0..cycles.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    int unsigned w;
    w = 32'd1;
    while ((64'd1 << w) < (64'(cycles) + 64'd1)) begin
      w = w + 32'd1;
    end
    return w;
  endfunction

endpackage

// File: rtl/sw_debouncer_bit.sv
// One switch lane: 2-flop synchronizer, stability counter, debounced level and edge pulses.
import sw_debouncer_pkg::*;

module debounce_bit #(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic rise,
  output logic fall,
  output logic load
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 32'd1);

  logic          r_s1;
  logic          r_s2;
  logic          r_stable;
  logic          r_rise;
  logic          r_fall;
  logic [CW-1:0] r_cnt;
  logic          w_mismatch;
  logic          w_load;

  assign w_mismatch = r_s2 ^ r_stable;
  assign w_load     = w_mismatch && (r_cnt == LAST);

  // Synchronize, qualify the mismatch for DEBOUNCE_CYCLES edges, then commit and pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_stable <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_s1   <= raw;
      r_s2   <= r_s1;
      r_rise <= w_load & r_s2;
      r_fall <= w_load & ~r_s2;
      if (w_load) begin
        r_stable <= r_s2;
        r_cnt    <= '0;
      end else if (w_mismatch) begin
        r_cnt <= r_cnt + CW'(1);
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign stable = r_stable;
  assign rise   = r_rise;
  assign fall   = r_fall;
  assign load   = w_load;

endmodule

// File: rtl/sw_debouncer.sv
// NBITS-wide switch debouncer with registered level, rise/fall pulses and a change flag.
import sw_debouncer_pkg::*;

module sw_debouncer #(
  parameter int unsigned NBITS           = DEF_NBITS,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NBITS-1:0] sw_raw,
  output logic [NBITS-1:0] sw,
  output logic [NBITS-1:0] sw_rise,
  output logic [NBITS-1:0] sw_fall,
  output logic             sw_changed
);

  logic [NBITS-1:0] w_load;
  logic             r_changed;

  for (genvar g = 0; g < NBITS; g++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk    (clk),
      .rst    (rst),
      .raw    (sw_raw[g]),
      .stable (sw[g]),
      .rise   (sw_rise[g]),
      .fall   (sw_fall[g]),
      .load   (w_load[g])
    );
  end

  // A load on any lane produces exactly one rise or fall pulse next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_changed <= 1'b0;
    end else begin
      r_changed <= |w_load;
    end
  end

  assign sw_changed = r_changed;

endmodule

// File: tb/tb_sw_debouncer.sv
// Directed vector bench for sw_debouncer (DEBOUNCE_CYCLES=4) plus a DEBOUNCE_CYCLES=1 instance.
module tb_sw_debouncer;

  typedef struct {
    logic       rst;
    logic [7:0] raw;
    logic [7:0] sw;
    logic [7:0] rise;
    logic [7:0] fall;
    logic       chg;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sw_raw;
  logic [7:0] sw;
  logic [7:0] sw_rise;
  logic [7:0] sw_fall;
  logic       sw_changed;

  logic       rst1;
  logic [7:0] sw_raw1;
  logic [7:0] sw1;
  logic [7:0] sw_rise1;
  logic [7:0] sw_fall1;
  logic       sw_changed1;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  sw_debouncer #(.NBITS(8), .DEBOUNCE_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .sw_raw     (sw_raw),
    .sw         (sw),
    .sw_rise    (sw_rise),
    .sw_fall    (sw_fall),
    .sw_changed (sw_changed)
  );

  sw_debouncer #(.NBITS(8), .DEBOUNCE_CYCLES(1)) dut1 (
    .clk        (clk),
    .rst        (rst1),
    .sw_raw     (sw_raw1),
    .sw         (sw1),
    .sw_rise    (sw_rise1),
    .sw_fall    (sw_fall1),
    .sw_changed (sw_changed1)
  );

  task automatic add(input logic r, input logic [7:0] raw, input logic [7:0] e_sw,
                     input logic [7:0] e_rise, input logic [7:0] e_fall, input int n);
    vec_t v;
    v.rst  = r;
    v.raw  = raw;
    v.sw   = e_sw;
    v.rise = e_rise;
    v.fall = e_fall;
    v.chg  = |(e_rise | e_fall);
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [7:0] a_sw, input logic [7:0] a_rise,
                       input logic [7:0] a_fall, input logic a_chg, input logic [7:0] e_sw,
                       input logic [7:0] e_rise, input logic [7:0] e_fall, input logic e_chg);
    n_vec++;
    if (a_sw !== e_sw || a_rise !== e_rise || a_fall !== e_fall || a_chg !== e_chg) begin
      n_err++;
      $display("FAIL %s: got sw=%h rise=%h fall=%h chg=%b, want sw=%h rise=%h fall=%h chg=%b",
               name, a_sw, a_rise, a_fall, a_chg, e_sw, e_rise, e_fall, e_chg);
    end
  endtask

  initial begin
    int n;
    rst     = 1'b1;
    sw_raw  = 8'h00;
    rst1    = 1'b1;
    sw_raw1 = 8'h00;

    // Reset with all switches high, then release and qualify.
    add(1'b1, 8'hFF, 8'h00, 8'h00, 8'h00, 2);
    add(1'b0, 8'hFF, 8'h00, 8'h00, 8'h00, 5);
    add(1'b0, 8'hFF, 8'hFF, 8'hFF, 8'h00, 1);
    add(1'b0, 8'hFF, 8'hFF, 8'h00, 8'h00, 2);
    // All fall.
    add(1'b0, 8'h00, 8'hFF, 8'h00, 8'h00, 5);
    add(1'b0, 8'h00, 8'h00, 8'h00, 8'hFF, 1);
    add(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 2);
    // Single bit 0 rise.
    add(1'b0, 8'h01, 8'h00, 8'h00, 8'h00, 5);
    add(1'b0, 8'h01, 8'h01, 8'h01, 8'h00, 1);
    add(1'b0, 8'h01, 8'h01, 8'h00, 8'h00, 2);
    // 3-cycle glitch on bit 3 is rejected.
    add(1'b0, 8'h09, 8'h01, 8'h00, 8'h00, 3);
    add(1'b0, 8'h01, 8'h01, 8'h00, 8'h00, 6);
    // Back to zero.
    add(1'b0, 8'h00, 8'h01, 8'h00, 8'h00, 5);
    add(1'b0, 8'h00, 8'h00, 8'h00, 8'h01, 1);
    add(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1);
    // Chatter 0F/F0 every 2 cycles, then settle on F0.
    for (int i = 0; i < 5; i++) begin
      add(1'b0, 8'h0F, 8'h00, 8'h00, 8'h00, 2);
      add(1'b0, 8'hF0, 8'h00, 8'h00, 8'h00, 2);
    end
    add(1'b0, 8'hF0, 8'h00, 8'h00, 8'h00, 3);
    add(1'b0, 8'hF0, 8'hF0, 8'hF0, 8'h00, 1);
    add(1'b0, 8'hF0, 8'hF0, 8'h00, 8'h00, 2);
    // F0 -> AA, then AA -> 55 with simultaneous rise and fall.
    add(1'b0, 8'hAA, 8'hF0, 8'h00, 8'h00, 5);
    add(1'b0, 8'hAA, 8'hAA, 8'h0A, 8'h50, 1);
    add(1'b0, 8'hAA, 8'hAA, 8'h00, 8'h00, 1);
    add(1'b0, 8'h55, 8'hAA, 8'h00, 8'h00, 5);
    add(1'b0, 8'h55, 8'h55, 8'h55, 8'hAA, 1);
    add(1'b0, 8'h55, 8'h55, 8'h00, 8'h00, 1);
    // Bit 5 mismatching, reset mid-qualification, full requalification after release.
    add(1'b0, 8'h75, 8'h55, 8'h00, 8'h00, 5);
    add(1'b1, 8'h75, 8'h00, 8'h00, 8'h00, 1);
    add(1'b0, 8'h75, 8'h00, 8'h00, 8'h00, 5);
    add(1'b0, 8'h75, 8'h75, 8'h75, 8'h00, 1);
    add(1'b0, 8'h75, 8'h75, 8'h00, 8'h00, 1);

    foreach (tbl[i]) begin
      rst    = tbl[i].rst;
      sw_raw = tbl[i].raw;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), sw, sw_rise, sw_fall, sw_changed,
            tbl[i].sw, tbl[i].rise, tbl[i].fall, tbl[i].chg);
    end

    // Bounded wait for the 75 -> 00 change; it must land on the 6th edge.
    sw_raw = 8'h00;
    n = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (sw_changed === 1'b1) begin
        n = c;
        break;
      end
    end
    n_vec++;
    if (n != 6) begin
      n_err++;
      $display("FAIL latency: got %0d edges (0 = timeout), want 6", n);
    end
    check("fall_75", sw, sw_rise, sw_fall, sw_changed, 8'h00, 8'h00, 8'h75, 1'b1);
    @(posedge clk);
    #1;
    check("fall_75_end", sw, sw_rise, sw_fall, sw_changed, 8'h00, 8'h00, 8'h00, 1'b0);

    // DEBOUNCE_CYCLES=1: updates on the first mismatching s2 edge.
    sw_raw1 = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    check("d1_rst", sw1, sw_rise1, sw_fall1, sw_changed1, 8'h00, 8'h00, 8'h00, 1'b0);
    rst1 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("d1_rise%0d", c), sw1, sw_rise1, sw_fall1, sw_changed1,
            (c >= 3) ? 8'hFF : 8'h00, (c == 3) ? 8'hFF : 8'h00, 8'h00, (c == 3));
    end
    sw_raw1 = 8'h00;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("d1_fall%0d", c), sw1, sw_rise1, sw_fall1, sw_changed1,
            (c >= 3) ? 8'h00 : 8'hFF, 8'h00, (c == 3) ? 8'hFF : 8'h00, (c == 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
